// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port data memory (IDLE -> ACCESS -> ACK).
// Optional build macro ARB_FIXED_PRIO_EN: r0 always wins ties and no last-grant register is kept.
module data_mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_read_addr,
  output logic [AW-1:0] mem_write_addr,
  output logic [DW-1:0] mem_write_val,
  output logic          mem_write_enable,
  input  logic [DW-1:0] mem_read_val
);

  // state  | meaning
  // IDLE   | no access in flight, waiting for any request
  // ACCESS | owner drives the memory port for one cycle
  // ACK    | owner receives its one-cycle ack, rdata valid
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner;
  logic [DW-1:0] r_r0_rdata;
  logic [DW-1:0] r_r1_rdata;
  logic          w_tie_pick;
  logic          w_idle_win;
  logic          w_other_req;
  logic          w_access;
  logic          w_ack;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_sel_we;

`ifdef ARB_FIXED_PRIO_EN
  assign w_tie_pick = 1'b0;
`else
  logic r_last;
  // The requester that was not granted most recently wins a tie.
  assign w_tie_pick = ~r_last;
`endif

  assign w_idle_win  = (r0_req & r1_req) ? w_tie_pick : r1_req;
  assign w_other_req = r_owner ? r0_req : r1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_r0_rdata <= '0;
      r_r1_rdata <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_last     <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r0_req | r1_req) begin
            r_state <= S_ACCESS;
            r_owner <= w_idle_win;
`ifndef ARB_FIXED_PRIO_EN
            r_last  <= w_idle_win;
`endif
          end
        end
        S_ACCESS: begin
          r_state <= S_ACK;
          if (r_owner) r_r1_rdata <= mem_read_val;
          else         r_r0_rdata <= mem_read_val;
        end
        S_ACK: begin
          // Owner's req is ignored here; only the other side can chain straight in.
          if (w_other_req) begin
            r_state <= S_ACCESS;
            r_owner <= ~r_owner;
`ifndef ARB_FIXED_PRIO_EN
            r_last  <= ~r_owner;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_access    = (r_state == S_ACCESS);
  assign w_ack       = (r_state == S_ACK);
  assign w_sel_addr  = r_owner ? r1_addr  : r0_addr;
  assign w_sel_wdata = r_owner ? r1_wdata : r0_wdata;
  assign w_sel_we    = r_owner ? r1_we    : r0_we;

  assign r0_gnt = w_access & ~r_owner;
  assign r1_gnt = w_access &  r_owner;
  assign r0_ack = w_ack & ~r_owner;
  assign r1_ack = w_ack &  r_owner;

  assign r0_rdata = r_r0_rdata;
  assign r1_rdata = r_r1_rdata;

  assign mem_read_addr    = w_access ? w_sel_addr  : '0;
  assign mem_write_addr   = w_access ? w_sel_addr  : '0;
  assign mem_write_val    = w_access ? w_sel_wdata : '0;
  assign mem_write_enable = w_access & w_sel_we;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter AW, 8, address width of the data memory port and of each requester address.
REQ-002 Parameter DW, 8, data width of the data memory port and of each requester data bus.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 r0_req  input  1  requester 0 access request; held high until r0_ack.
REQ-006 r0_we  input  1  requester 0 write (1) / read (0); stable while r0_req high.
REQ-007 r0_addr  input  AW  requester 0 address; stable while r0_req high.
REQ-008 r0_wdata  input  DW  requester 0 write data; stable while r0_req high.
REQ-009 r0_gnt  output  1  high during requester 0's ACCESS cycle.
REQ-010 r0_ack  output  1  one-cycle completion pulse to requester 0.
REQ-011 r0_rdata  output  DW  registered read data for requester 0.
REQ-012 r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_ack, r1_rdata: same directions, widths and meanings as REQ-005..011, for requester 1.
REQ-013 mem_read_addr  output  AW  to data memory read address.
REQ-014 mem_write_addr  output  AW  to data memory write address.
REQ-015 mem_write_val  output  DW  to data memory write value.
REQ-016 mem_write_enable  output  1  to data memory write enable (memory writes on clk rising edge).
REQ-017 mem_read_val  input  DW  from data memory, combinational read of mem_read_addr.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, ACK; reset state IDLE.
REQ-019 IDLE -> ACCESS when any req is high at the edge; the winner is latched as the owner; otherwise stay IDLE.
REQ-020 ACCESS SHALL last exactly one cycle, then go to ACK.
REQ-021 In ACCESS: owner's gnt = 1; mem_read_addr = mem_write_addr = owner addr; mem_write_val = owner wdata; mem_write_enable = owner we.
REQ-022 Outside ACCESS: all gnt, mem_write_enable, mem_read_addr, mem_write_addr, mem_write_val SHALL be 0.
REQ-023 At the edge ending ACCESS, owner's rdata SHALL load mem_read_val (old content on a write, i.e. read-before-write); the other rdata holds.
REQ-024 In ACK: owner's ack = 1 for exactly one cycle; rdata valid from this cycle until that requester's next ack.
REQ-025 ACK -> ACCESS if the non-owner's req is high (it becomes owner); else ACK -> IDLE; the owner's req is ignored during ACK.
REQ-026 Arbitration is round-robin: on a tie the requester not granted most recently wins; the last-grant register resets to 1, so r0 wins the first tie.
REQ-027 Latency: req seen high in IDLE -> gnt next cycle -> ack the cycle after; minimum 3 cycles per access per requester, 2-cycle spacing when alternating.
REQ-028 A req dropped before its grant SHALL be ignored; no memory access and no ack for it.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, all gnt/ack/mem_* outputs 0, both rdata 0, last-grant 1.
REQ-030 Reset during ACCESS SHALL drop mem_write_enable combinationally, with no ack issued; the in-flight request restarts only if req is still high after reset release.

Configuration
REQ-031 Macro ARB_FIXED_PRIO_EN: defined -> r0 always wins ties and the last-grant register is not built; undefined -> round-robin per REQ-026.

Verification
REQ-032 Single read: mem[3]=5, r0 reads addr 3 -> r0_gnt at cycle 1, r0_ack at cycle 2, r0_rdata=5; r1 outputs stay 0.
REQ-033 Write then read: r1 writes 9 to addr 2 (old 5) -> r1_rdata=5, then r1 reads addr 2 -> r1_rdata=9.
REQ-034 Simultaneous req from IDLE after reset -> grant order r0, r1, r0, r1 while both held; ACK->ACCESS back-to-back with no IDLE; with ARB_FIXED_PRIO_EN -> r0 wins every IDLE tie.
REQ-035 rst_n low in the ACCESS cycle of an r0 write of 7 to addr 4 (old 5) -> mem[4] stays 5, no r0_ack, all outputs 0.
REQ-036 r1_req pulsed for one cycle while r0 is in ACCESS -> no r1_gnt and no r1_ack ever; FSM returns to IDLE after r0_ack.
